// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch path: hold, increment, load, call and
// return, with a small LIFO of return addresses and sticky misuse flags.
module pc_sequencer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  input  logic             call,
  input  logic [WIDTH-1:0] call_addr,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [SPW-1:0]   sp_level,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] stack [DEPTH];

  logic [WIDTH-1:0] inc;
  logic [WIDTH-1:0] pc_nxt;
  logic [SPW-1:0]   sp_nxt;
  logic [SPW-1:0]   sp_dec;
  logic             ovf_nxt;
  logic             unf_nxt;
  logic             push;

  assign stack_full  = (sp_level == SPW'(DEPTH));
  assign stack_empty = (sp_level == SPW'(0));

  // One shared incrementer feeds both the sequential path and the pushed return address.
  assign inc    = pc + WIDTH'(1);
  assign sp_dec = sp_level - SPW'(1);

  // Next-state selection in priority order: stall > ret > call > load > increment.
  always_comb begin
    pc_nxt  = inc;
    sp_nxt  = sp_level;
    ovf_nxt = overflow_err;
    unf_nxt = underflow_err;
    push    = 1'b0;
    if (stall) begin
      pc_nxt = pc;
    end else if (ret) begin
      if (!stack_empty) begin
        pc_nxt = stack[sp_dec[AW-1:0]];
        sp_nxt = sp_dec;
      end else begin
        unf_nxt = 1'b1;
      end
    end else if (call) begin
      if (!stack_full) begin
        push   = 1'b1;
        sp_nxt = sp_level + SPW'(1);
        pc_nxt = call_addr;
      end else begin
        ovf_nxt = 1'b1;
      end
    end else if (load) begin
      pc_nxt = load_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc            <= '0;
      sp_level      <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      pc            <= pc_nxt;
      sp_level      <= sp_nxt;
      overflow_err  <= ovf_nxt;
      underflow_err <= unf_nxt;
    end
  end

  // Stack contents carry no reset; only the level counter defines validity.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      stack[sp_level[AW-1:0]] <= inc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, load, call, ret;
  logic [15:0] load_addr, call_addr;
  logic [15:0] pc;
  logic [2:0]  sp_level;
  logic        stack_full, stack_empty, overflow_err, underflow_err;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(.WIDTH(16), .DEPTH(4), .SPW(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .load         (load),
    .load_addr    (load_addr),
    .call         (call),
    .call_addr    (call_addr),
    .ret          (ret),
    .pc           (pc),
    .sp_level     (sp_level),
    .stack_full   (stack_full),
    .stack_empty  (stack_empty),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; stall = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0;
  endtask

  task automatic check_stack(input string tag, input logic [2:0] lvl,
                             input logic full, input logic empty);
    check({tag, ".sp"},    32'(sp_level),    32'(lvl));
    check({tag, ".full"},  32'(stack_full),  32'(full));
    check({tag, ".empty"}, 32'(stack_empty), 32'(empty));
  endtask

  task automatic check_err(input string tag, input logic ovf, input logic unf);
    check({tag, ".ovf"}, 32'(overflow_err),  32'(ovf));
    check({tag, ".unf"}, 32'(underflow_err), 32'(unf));
  endtask

  logic [15:0] ovf_ret [4];

  initial begin
    ovf_ret = '{16'h0A01, 16'h0A01, 16'h0A01, 16'h0001};
    idle();
    load_addr = '0;
    call_addr = '0;

    // Reset, then free-running increment
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst.pc", 32'(pc), 32'h0);
    check_stack("rst", 3'd0, 1'b0, 1'b1);
    check_err("rst", 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("inc%0d.pc", i), 32'(pc), 32'(i));
    end

    // Wrap-around
    load = 1'b1; load_addr = 16'hFFFE;
    step();
    check("wrap.load", 32'(pc), 32'hFFFE);
    idle();
    step();
    check("wrap.ffff", 32'(pc), 32'hFFFF);
    step();
    check("wrap.zero", 32'(pc), 32'h0000);
    check_err("wrap", 1'b0, 1'b0);

    // Nested call/return
    load = 1'b1; load_addr = 16'h0010;
    step();
    load = 1'b0; call = 1'b1; call_addr = 16'h0100;
    step();
    check("call1.pc", 32'(pc), 32'h0100);
    check_stack("call1", 3'd1, 1'b0, 1'b0);
    idle();
    step();
    step();
    check("pre2.pc", 32'(pc), 32'h0102);
    call = 1'b1; call_addr = 16'h0200;
    step();
    check("call2.pc", 32'(pc), 32'h0200);
    check("call2.sp", 32'(sp_level), 32'd2);
    idle(); ret = 1'b1;
    step();
    check("ret1.pc", 32'(pc), 32'h0103);
    check("ret1.sp", 32'(sp_level), 32'd1);
    step();
    check("ret2.pc", 32'(pc), 32'h0011);
    check_stack("ret2", 3'd0, 1'b0, 1'b1);

    // Overflow
    idle(); reset = 1'b1;
    step();
    idle(); call = 1'b1; call_addr = 16'h0A00;
    for (int i = 0; i < 4; i++) step();
    check("fill.pc", 32'(pc), 32'h0A00);
    check_stack("fill", 3'd4, 1'b1, 1'b0);
    check_err("fill", 1'b0, 1'b0);
    step();
    check("ovf.pc", 32'(pc), 32'h0A01);
    check_stack("ovf", 3'd4, 1'b1, 1'b0);
    check_err("ovf", 1'b1, 1'b0);
    idle(); ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("pop%0d.pc", i), 32'(pc), 32'(ovf_ret[i]));
    end
    check_stack("popall", 3'd0, 1'b0, 1'b1);

    // Underflow and stall
    idle(); load = 1'b1; load_addr = 16'h0020;
    step();
    idle(); ret = 1'b1;
    step();
    check("unf.pc", 32'(pc), 32'h0021);
    check_err("unf", 1'b1, 1'b1);
    check("unf.sp", 32'(sp_level), 32'd0);
    idle(); stall = 1'b1; load = 1'b1; load_addr = 16'h1234;
    step();
    check("stall.pc", 32'(pc), 32'h0021);
    load = 1'b0; call = 1'b1; call_addr = 16'h0777;
    step();
    check("stall_call.pc", 32'(pc), 32'h0021);
    check_stack("stall_call", 3'd0, 1'b0, 1'b1);
    idle();
    step();
    check("unstall.pc", 32'(pc), 32'h0022);

    // Priority: ret beats call and load
    load = 1'b1; load_addr = 16'h004F;
    step();
    idle(); call = 1'b1; call_addr = 16'h0600;
    step();
    check("pri_setup.pc", 32'(pc), 32'h0600);
    check("pri_setup.sp", 32'(sp_level), 32'd1);
    ret = 1'b1; call = 1'b1; call_addr = 16'h0300; load = 1'b1; load_addr = 16'h0400;
    step();
    check("pri.pc", 32'(pc), 32'h0050);
    check_stack("pri", 3'd0, 1'b0, 1'b1);
    check_err("pri", 1'b1, 1'b1);

    // Reset dominates a concurrent call
    idle(); load = 1'b1; load_addr = 16'h0123;
    step();
    idle(); reset = 1'b1; call = 1'b1; call_addr = 16'h0300;
    step();
    check("rst2.pc", 32'(pc), 32'h0);
    check_stack("rst2", 3'd0, 1'b0, 1'b1);
    check_err("rst2", 1'b0, 1'b0);
    idle();
    step();
    check("rst2.inc", 32'(pc), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
